conway_row_window: RTL and testbench

Streaming three-row window buffer that sits directly upstream of the parallel next-state array. Full-width rows arrive one at a time from frame memory in raster order. The block presents each row as the middle row of a top/middle/bottom window and zero-pads above row 0 and below the last row. The next-state array consumes one window per handshake and produces one result row per window.

---
 rtl/conway_row_window_if.sv | 35 +++
 rtl/conway_row_window.sv | 153 +++++++++++++++
 tb/tb_conway_row_window.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/conway_row_window_if.sv
`default_nettype none
// =============================================================================
// Module  : conway_row_window_if
// Brief   : Row-in / window-out handshake bundle for conway_row_window.
// Revision: 1.0
// =============================================================================
interface conway_row_window_if #(
    parameter int ROW_LENGTH = 1280,
    parameter int NUM_ROWS   = 720
);
    localparam int IDX_W = $clog2(NUM_ROWS);

    logic                  start;
    logic [ROW_LENGTH-1:0] in_row;
    logic                  in_valid;
    logic                  in_ready;
    logic [ROW_LENGTH-1:0] top_row;
    logic [ROW_LENGTH-1:0] middle_row;
    logic [ROW_LENGTH-1:0] bottom_row;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_row_idx;
    logic                  frame_done;

    modport master (
        output start, in_row, in_valid, out_ready,
        input  in_ready, top_row, middle_row, bottom_row, out_valid, out_row_idx, frame_done
    );

    modport slave (
        input  start, in_row, in_valid, out_ready,
        output in_ready, top_row, middle_row, bottom_row, out_valid, out_row_idx, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/conway_row_window.sv
`default_nettype none
// =============================================================================
// Module  : conway_row_window
// Brief   : Three-row sliding window with zero padding above/below the frame.
// Revision: 1.0
// =============================================================================
module conway_row_window #(
    parameter int ROW_LENGTH = 1280,
    parameter int NUM_ROWS   = 720
) (
    input  logic                  clk,
    input  logic                  rst,
    conway_row_window_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_ROWS);
    localparam int CNT_W = $clog2(NUM_ROWS + 1);
    localparam logic [CNT_W-1:0] C_NUM_ROWS = CNT_W'(NUM_ROWS);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t                state_q,       state_d;
    logic [ROW_LENGTH-1:0] win_top_q,     win_top_d;
    logic [ROW_LENGTH-1:0] win_mid_q,     win_mid_d;
    logic [ROW_LENGTH-1:0] win_bot_q,     win_bot_d;
    logic [CNT_W-1:0]      rows_in_q,     rows_in_d;
    logic                  out_valid_q,   out_valid_d;
    logic [IDX_W-1:0]      out_row_idx_q, out_row_idx_d;
    logic                  frame_done_q,  frame_done_d;

    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;

    // Accepting a new row in STREAM needs the current window to leave (or be empty).
    always_comb begin
        w_in_ready = 1'b0;
        case (state_q)
            S_FILL:   w_in_ready = 1'b1;
            S_STREAM: w_in_ready = (rows_in_q < C_NUM_ROWS) & (~out_valid_q | bus.out_ready);
            default:  w_in_ready = 1'b0;
        endcase
    end

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = out_valid_q & bus.out_ready;

    always_comb begin
        state_d       = state_q;
        win_top_d     = win_top_q;
        win_mid_d     = win_mid_q;
        win_bot_d     = win_bot_q;
        rows_in_d     = rows_in_q;
        out_valid_d   = out_valid_q;
        out_row_idx_d = out_row_idx_q;
        frame_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    win_top_d     = '0;
                    win_mid_d     = '0;
                    win_bot_d     = '0;
                    rows_in_d     = '0;
                    out_row_idx_d = '0;
                    state_d       = S_FILL;
                end
            end
            S_FILL: begin
                if (w_in_fire) begin
                    win_top_d = win_mid_q;
                    win_mid_d = win_bot_q;
                    win_bot_d = bus.in_row;
                    rows_in_d = rows_in_q + C_ONE;
                    if (rows_in_q == C_ONE) begin
                        out_valid_d = 1'b1;
                        state_d     = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (w_in_fire) begin
                    win_top_d   = win_mid_q;
                    win_mid_d   = win_bot_q;
                    win_bot_d   = bus.in_row;
                    rows_in_d   = rows_in_q + C_ONE;
                    out_valid_d = 1'b1;
                    if (w_out_fire) begin
                        out_row_idx_d = out_row_idx_q + C_IDX_ONE;
                    end
                end else if (w_out_fire) begin
                    out_row_idx_d = out_row_idx_q + C_IDX_ONE;
                    if (rows_in_q == C_NUM_ROWS) begin
                        // Last real row becomes the centre; pad below with zeros.
                        win_top_d = win_mid_q;
                        win_mid_d = win_bot_q;
                        win_bot_d = '0;
                        state_d   = S_FLUSH;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                if (w_out_fire) begin
                    out_valid_d   = 1'b0;
                    frame_done_d  = 1'b1;
                    out_row_idx_d = '0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            win_top_q     <= '0;
            win_mid_q     <= '0;
            win_bot_q     <= '0;
            rows_in_q     <= '0;
            out_valid_q   <= 1'b0;
            out_row_idx_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_top_q     <= win_top_d;
            win_mid_q     <= win_mid_d;
            win_bot_q     <= win_bot_d;
            rows_in_q     <= rows_in_d;
            out_valid_q   <= out_valid_d;
            out_row_idx_q <= out_row_idx_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.top_row     = win_top_q;
    assign bus.middle_row  = win_mid_q;
    assign bus.bottom_row  = win_bot_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_row_idx = out_row_idx_q;
    assign bus.frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conway_row_window.sv
`default_nettype none
// Random and directed frames through conway_row_window; windows are predicted
// from the frame's rows and checked by a separate negedge monitor.
module tb_conway_row_window;
    localparam int W   = 8;
    localparam int NR  = 4;
    localparam int IW  = $clog2(NR);
    localparam int NR2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conway_row_window_if #(.ROW_LENGTH(W), .NUM_ROWS(NR))  bus  ();
    conway_row_window_if #(.ROW_LENGTH(W), .NUM_ROWS(NR2)) bus2 ();

    conway_row_window #(.ROW_LENGTH(W), .NUM_ROWS(NR))  dut  (.clk(clk), .rst(rst), .bus(bus));
    conway_row_window #(.ROW_LENGTH(W), .NUM_ROWS(NR2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct packed {
        logic [W-1:0]  t;
        logic [W-1:0]  m;
        logic [W-1:0]  b;
        logic [IW-1:0] idx;
    } win_t;

    win_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   fd_pending = 1'b0;
    bit   hold_prev  = 1'b0;
    win_t prev_win;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected window per out_fire, checks hold stability and frame_done.
    always @(negedge clk) begin
        win_t cur;
        win_t e;
        if (rst) begin
            hold_prev  = 1'b0;
            fd_pending = 1'b0;
        end else begin
            cur.t   = bus.top_row;
            cur.m   = bus.middle_row;
            cur.b   = bus.bottom_row;
            cur.idx = bus.out_row_idx;
            check("frame_done", 64'(bus.frame_done), 64'(fd_pending));
            fd_pending = 1'b0;
            if (bus.out_valid) begin
                if (hold_prev) check("hold_stable", 64'(cur), 64'(prev_win));
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL window_unexpected: got %0h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("window", 64'(cur), 64'(e));
                        if (e.idx == IW'(NR - 1)) fd_pending = 1'b1;
                    end
                    hold_prev = 1'b0;
                end else begin
                    check("in_ready_backpressure", 64'(bus.in_ready), 64'(0));
                    hold_prev = 1'b1;
                    prev_win  = cur;
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_top"},        64'(bus.top_row),     64'(0));
        check({tag, "_mid"},        64'(bus.middle_row),  64'(0));
        check({tag, "_bot"},        64'(bus.bottom_row),  64'(0));
        check({tag, "_out_valid"},  64'(bus.out_valid),   64'(0));
        check({tag, "_in_ready"},   64'(bus.in_ready),    64'(0));
        check({tag, "_idx"},        64'(bus.out_row_idx), 64'(0));
        check({tag, "_frame_done"}, 64'(bus.frame_done),  64'(0));
    endtask

    // mode: 0 basic, 1 random, 2 starvation, 3 backpressure, 4 overrun+stray start, 5 reset after 3 rows
    task automatic run_frame(input int mode, input bit chain, input bit pre_started);
        logic [W-1:0] rows [NR];
        win_t w;
        int   acc  = 0;
        int   cyc  = 0;
        int   hold = 0;
        bit   done = 1'b0;
        bit   iv;
        bit   orr;
        for (int k = 0; k < NR; k++) rows[k] = (mode == 0) ? W'(1 << k) : W'($urandom);
        for (int k = 0; k < NR; k++) begin
            w.t   = (k > 0)      ? rows[k-1] : '0;
            w.m   = rows[k];
            w.b   = (k < NR - 1) ? rows[k+1] : '0;
            w.idx = IW'(k);
            exp_q.push_back(w);
        end
        if (!pre_started) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        while (!done) begin
            case (mode)
                1: begin iv = ($urandom % 4) != 0; orr = ($urandom % 3) != 0; end
                2: begin iv = (cyc % 2) == 0; orr = 1'b1; end
                3: begin
                    iv  = 1'b1;
                    orr = !(bus.out_valid && bus.out_row_idx == IW'(1) && hold < 5);
                    if (!orr) hold++;
                end
                default: begin iv = 1'b1; orr = 1'b1; end
            endcase
            bus.in_valid  = (acc < NR) ? iv : (mode == 4);
            bus.in_row    = (acc < NR) ? rows[acc] : '1;
            bus.out_ready = orr;
            bus.start     = (mode == 4 && cyc == 3);
            @(negedge clk);
            if (acc < 2)   check("fill_in_ready", 64'(bus.in_ready), 64'(1));
            if (acc >= NR) check("in_ready_after_last_row", 64'(bus.in_ready), 64'(0));
            if (bus.in_valid && bus.in_ready) acc++;
            if (mode == 5 && acc == 3) begin
                @(posedge clk); #1;
                rst = 1'b1;
                #1;
                check_all_zero("reset_mid");
                exp_q.delete();
                repeat (2) @(posedge clk);
                #3 rst = 1'b0;
                done = 1'b1;
            end else begin
                if (bus.frame_done) begin
                    done = 1'b1;
                    if (mode == 0) check("basic_frame_cycles", 64'(cyc), 64'(6));
                    if (chain) bus.start = 1'b1;
                end
                @(posedge clk); #1;
                bus.start = 1'b0;
                cyc++;
                if (!done && cyc > 300) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL frame_timeout: got no frame_done expected one (mode %0d)", mode);
                    done = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_min_frame();
        logic [W-1:0]   r    [2];
        logic [3*W-1:0] expw [2];
        int k    = 0;
        int acc  = 0;
        bit done = 1'b0;
        r[0] = 8'hAA; r[1] = 8'h55;
        expw[0] = {8'h00, 8'hAA, 8'h55};
        expw[1] = {8'hAA, 8'h55, 8'h00};
        bus2.out_ready = 1'b1;
        bus2.start     = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            bus2.in_valid = (acc < 2);
            bus2.in_row   = (acc < 2) ? r[acc] : '0;
            @(negedge clk);
            if (bus2.in_valid && bus2.in_ready) acc++;
            if (bus2.out_valid) begin
                if (k < 2) begin
                    check("min_window", 64'({bus2.top_row, bus2.middle_row, bus2.bottom_row}), 64'(expw[k]));
                    check("min_idx", 64'(bus2.out_row_idx), 64'(k));
                end else begin
                    n_chk++;
                    n_err++;
                    $display("FAIL min_extra_window: got window %0d expected 2 only", k);
                end
                k++;
            end
            if (bus2.frame_done) begin
                check("min_windows_before_done", 64'(k), 64'(2));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL min_timeout: got no frame_done expected one");
        end
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        bus.start  = 1'b0; bus.in_valid  = 1'b0; bus.in_row  = '0; bus.out_ready  = 1'b0;
        bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_row = '0; bus2.out_ready = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle");
        run_frame(0, 1'b0, 1'b0);
        run_frame(3, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b0);
        run_frame(5, 1'b0, 1'b0);
        run_frame(0, 1'b0, 1'b0);
        run_frame(4, 1'b1, 1'b0);
        run_frame(0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) run_frame(1, 1'b0, 1'b0);
        run_min_frame();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
